// File: rtl/sseg_scan_decoder.sv
// Purpose: sample a scanned an/sseg/dp display bus, debounce each digit phase, decode it to a hex nibble and reassemble 16-bit frames.
// Latency: 2 sync + SETTLE + 1 accept + 1 frame cycles after the bus settles on the last new digit.
// Backpressure: none; this is a passive monitor, and frame_valid is a pulse that cannot be stalled.
// Optional: define SSEG_DP_CAPTURE_EN to latch the per-digit decimal points onto dp_out; otherwise dp_out is 0.
module sseg_scan_decoder #(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT   = 1000000,
    parameter int TIMEOUT_W = 24
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale,
    output logic [3:0]  dp_out
);

    typedef enum logic [1:0] {S_WAIT, S_ACCEPT, S_HOLD} state_t;

    localparam logic [3:0]           SETTLE_C = 4'(SETTLE);
    localparam logic [TIMEOUT_W-1:0] TO_MAX   = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] TO_ONE   = TIMEOUT_W'(1);

    // Bit 4 flags a pattern that is not one of the sixteen hex glyphs.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    logic [3:0]           an_meta_q, an_sync_q, an_prev_q;
    logic [6:0]           sseg_meta_q, sseg_sync_q, sseg_prev_q;
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0][3:0]      slot_q, slot_d;
    logic [3:0]           mask_q, mask_d;
    logic                 err_acc_q, err_acc_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [15:0]          value_q, value_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 stale_q, stale_d;

    logic                 sample_chg, an_legal, accept, frame, timeout_hit;
    logic [1:0]           slot_idx;
    logic [4:0]           dec;

    // Two-flop synchronizers for the asynchronous display bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            an_meta_q   <= '0;
            an_sync_q   <= '0;
            sseg_meta_q <= '0;
            sseg_sync_q <= '0;
        end else begin
            an_meta_q   <= an;
            an_sync_q   <= an_meta_q;
            sseg_meta_q <= sseg;
            sseg_sync_q <= sseg_meta_q;
        end
    end

    // Stability counting, digit FSM, slot assembly, frame completion and timeout.
    always_comb begin
        sample_chg  = (an_sync_q != an_prev_q) || (sseg_sync_q != sseg_prev_q);
        an_legal    = (an_sync_q == 4'b1110) || (an_sync_q == 4'b1101) ||
                      (an_sync_q == 4'b1011) || (an_sync_q == 4'b0111);
        accept      = (state_q == S_ACCEPT);
        frame       = (mask_q == 4'b1111);
        timeout_hit = (to_q == TO_MAX);
        // an_prev_q/sseg_prev_q hold the sample that satisfied the settle count.
        dec         = decode(sseg_prev_q);
        case (an_prev_q)
            4'b1101: slot_idx = 2'd1;
            4'b1011: slot_idx = 2'd2;
            4'b0111: slot_idx = 2'd3;
            default: slot_idx = 2'd0;
        endcase

        if (sample_chg)              cnt_d = 4'd1;
        else if (cnt_q >= SETTLE_C)  cnt_d = SETTLE_C;
        else                         cnt_d = cnt_q + 4'd1;

        state_d = state_q;
        case (state_q)
            S_WAIT:   if (cnt_d == SETTLE_C && an_legal) state_d = S_ACCEPT;
            S_ACCEPT: state_d = sample_chg ? S_WAIT : S_HOLD;
            S_HOLD:   if (sample_chg) state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase

        slot_d    = slot_q;
        mask_d    = mask_q;
        err_acc_d = err_acc_q;
        if (frame || timeout_hit) begin
            mask_d    = '0;
            err_acc_d = 1'b0;
        end
        // An accept wins over a timeout clear so the first digit after a stale period is kept.
        if (accept) begin
            slot_d[slot_idx] = dec[3:0];
            mask_d           = mask_d | (4'b0001 << slot_idx);
            err_acc_d        = err_acc_d | dec[4];
        end

        if (accept)           to_d = '0;
        else if (timeout_hit) to_d = to_q;
        else                  to_d = to_q + TO_ONE;

        if (accept)           stale_d = 1'b0;
        else if (timeout_hit) stale_d = 1'b1;
        else                  stale_d = stale_q;

        value_d       = frame ? slot_q : value_q;
        frame_err_d   = frame ? err_acc_q : frame_err_q;
        frame_valid_d = frame;
    end

    // Register FSM and datapath state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            an_prev_q     <= '0;
            sseg_prev_q   <= '0;
            state_q       <= S_WAIT;
            cnt_q         <= '0;
            slot_q        <= '0;
            mask_q        <= '0;
            err_acc_q     <= 1'b0;
            to_q          <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            an_prev_q     <= an_sync_q;
            sseg_prev_q   <= sseg_sync_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            mask_q        <= mask_d;
            err_acc_q     <= err_acc_d;
            to_q          <= to_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;

`ifdef SSEG_DP_CAPTURE_EN
    logic       dp_meta_q, dp_sync_q, dp_prev_q;
    logic [3:0] dp_slot_q, dp_slot_d;
    logic [3:0] dp_out_q, dp_out_d;

    // Per-slot decimal point capture, published together with the frame.
    always_comb begin
        dp_slot_d = dp_slot_q;
        if (accept) dp_slot_d[slot_idx] = ~dp_prev_q;
        dp_out_d = frame ? dp_slot_q : dp_out_q;
    end

    // Synchronize dp alongside the bus and register captured points.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dp_meta_q <= 1'b0;
            dp_sync_q <= 1'b0;
            dp_prev_q <= 1'b0;
            dp_slot_q <= '0;
            dp_out_q  <= '0;
        end else begin
            dp_meta_q <= dp;
            dp_sync_q <= dp_meta_q;
            dp_prev_q <= dp_sync_q;
            dp_slot_q <= dp_slot_d;
            dp_out_q  <= dp_out_d;
        end
    end

    assign dp_out = dp_out_q;
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign dp_out    = 4'b0000;
`endif

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the scanned an/sseg/dp bus, filters transitions and decodes each segment pattern back to a hex nibble.
- Reassembles the four digits into a 16-bit value and pulses a valid strobe once per complete scan frame.
- Used as an on-chip display monitor so benches and self-checks can read back the shown step count.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a digit is accepted (1..15).
- TIMEOUT, 1000000: clocks without any accepted digit before the frame is declared stale.
- TIMEOUT_W, 24: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset (0 = in reset).
- an  input  4  anode selects, active-low; digit k is driven when an[k]=0 and all other bits are 1.
- sseg  input  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- dp  input  1  decimal point, active-low.
- value  output  16  last complete frame, {digit3,digit2,digit1,digit0}.
- frame_valid  output  1  one-cycle pulse when value updates.
- frame_err  output  1  set with frame_valid if any digit in that frame was undecodable.
- stale  output  1  high while no digit has been accepted for TIMEOUT clocks.
- dp_out  output  4  per-digit decimal point, active-high (see Optional Feature).

Behaviour:
- Reset values: value=0, frame_valid=0, frame_err=0, stale=0, dp_out=0. Slot mask, error accumulator, timeout counter and synchronizers are also cleared.
- Synchronization: an, sseg and dp each pass through a 2-flop synchronizer. All further logic uses the synchronized copies.
- FSM states:
  - WAIT: on a sample change, reload the stability count to 1. When the count reaches SETTLE and an is a legal one-hot-low code, go to ACCEPT.
  - ACCEPT: one cycle. Write the decoded nibble to slot k, set mask bit k and OR the decode error into the accumulator. Then go to HOLD.
  - HOLD: stay until the synchronized an or sseg changes, then return to WAIT. This prevents re-accepting the same phase.
- Illegal an (0xF, or more than one bit low) never leaves WAIT and does not reset the timeout counter.
- Decode table (pattern -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - Any other pattern stores nibble 0 and flags a decode error.
- Re-accepting a slot already in the mask overwrites its nibble. The error accumulator keeps OR-ing.
- Frame completion:
  - Occurs the cycle after the ACCEPT that makes the mask 4'b1111.
  - value, frame_err and dp_out update from the slots; frame_valid=1 for exactly that cycle.
  - Mask and accumulator clear in the same cycle.
- Latency: 2 sync cycles + SETTLE + 1 (ACCEPT) + 1 (frame) after the bus settles on the last new digit.
- Timeout:
  - The counter resets on every ACCEPT and otherwise increments, saturating at TIMEOUT.
  - At TIMEOUT: stale=1, and mask and accumulator clear.
  - stale clears on the next ACCEPT; value is held.
- RESET asserted mid-frame discards any partial frame immediately.

Optional Feature:
- Macro: SSEG_DP_CAPTURE_EN.
- Defined: the synchronized dp is latched per slot on ACCEPT. dp_out[k] = NOT dp for digit k, updated at frame completion.
- Undefined: dp is ignored, no dp storage is synthesized, and dp_out is tied to 0.

Test Plan:
- Scan 1234: drive an=1110/sseg=0011001, 1101/0110000, 1011/0100100, 0111/1111001, 20 clocks each -> one frame_valid pulse, value=16'h1234, frame_err=0.
- Glitch filtering (SETTLE=4): a 2-cycle sseg glitch inside a digit phase -> no extra accept, and value is unchanged from the glitch-free result.
- Bad pattern 1111111 on digit2 during a scan of 0xABCD -> value=16'hA0CD, frame_err=1. The next clean frame gives frame_err=0.
- Bus stuck at an=1111 with TIMEOUT=100 -> stale=1 about 100 clocks after the last accept. The next full scan of 0x0042 clears stale and sets value=16'h0042.
- RESET pulsed low after two digits accepted, then a full scan of 0x9876 -> exactly one frame_valid pulse with value=16'h9876, and no frame built from the stale partial digits.
- With SSEG_DP_CAPTURE_EN defined and dp=0 only on digit1 -> dp_out=4'b0010. With the macro undefined -> dp_out=0.
